// File: rtl/commit_port_arbiter.sv
// Arbitrates six execute-stage result producers onto the two registered commit lanes.
// Define COMMIT_ARB_STARVE_GUARD_EN to add per-requester wait counters that can override mul_div priority.
module commit_port_arbiter #(
   parameter int PAYLOAD_W    = 160,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 flush_i,
   input  logic                 alu1_valid_i,
   output logic                 alu1_ready_o,
   input  logic [PAYLOAD_W-1:0] alu1_bus_i,
   input  logic                 bru_valid_i,
   output logic                 bru_ready_o,
   input  logic [PAYLOAD_W-1:0] bru_bus_i,
   input  logic                 alu2_valid_i,
   output logic                 alu2_ready_o,
   input  logic [PAYLOAD_W-1:0] alu2_bus_i,
   input  logic                 agu_valid_i,
   output logic                 agu_ready_o,
   input  logic [PAYLOAD_W-1:0] agu_bus_i,
   input  logic                 sp_valid_i,
   output logic                 sp_ready_o,
   input  logic [PAYLOAD_W-1:0] sp_bus_i,
   input  logic                 mul_div_valid_i,
   output logic                 mul_div_ready_o,
   input  logic [PAYLOAD_W-1:0] mul_div_bus1_i,
   input  logic [PAYLOAD_W-1:0] mul_div_bus2_i,
   input  logic                 commit_ready_i,
   output logic [PAYLOAD_W-1:0] commit_bus1_o,
   output logic [PAYLOAD_W-1:0] commit_bus2_o,
   output logic                 commit_valid1_o,
   output logic                 commit_valid2_o
);

   localparam int NREQ = 5;
   localparam int ALU1 = 0;
   localparam int BRU  = 1;
   localparam int AGU  = 2;
   localparam int ALU2 = 3;
   localparam int SP   = 4;

   if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : gBadStarveLimit
      $error("commit_port_arbiter: STARVE_LIMIT must be in 1..15");
   end

   logic                 valid1_q, valid2_q;
   logic [PAYLOAD_W-1:0] bus1_q, bus2_q;
   logic [PAYLOAD_W-1:0] bus1_d, bus2_d;
   logic                 lane1Ptr_q, lane1Ptr_d;
   logic [1:0]           lane2Ptr_q, lane2Ptr_d;
   logic [NREQ-1:0]      reqValid;
   logic [NREQ-1:0]      laneGrant;
   logic [3:0]           lane2Req;
   logic                 take, grantEn, laneEn, mdGrant, starveHit;

   assign reqValid = {sp_valid_i, alu2_valid_i, agu_valid_i, bru_valid_i, alu1_valid_i};
   // Lane-2 requesters in pointer order (0=agu, 1=alu2, 2=sp); slot 3 never requests.
   assign lane2Req = {1'b0, sp_valid_i, alu2_valid_i, agu_valid_i};

   assign take    = !(valid1_q || valid2_q) || commit_ready_i;
   assign grantEn = take && !flush_i && !reset;
   assign mdGrant = grantEn && mul_div_valid_i && !starveHit;
   assign laneEn  = grantEn && !mdGrant;

   function automatic logic [1:0] wrapInc(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   always_comb begin
      logic [1:0] cand;
      logic       found;
      laneGrant  = '0;
      lane1Ptr_d = lane1Ptr_q;
      lane2Ptr_d = lane2Ptr_q;
      cand       = lane2Ptr_q;
      found      = 1'b0;
      if (laneEn) begin
         if (alu1_valid_i && (!lane1Ptr_q || !bru_valid_i)) begin
            laneGrant[ALU1] = 1'b1;
            lane1Ptr_d      = 1'b1;
         end else if (bru_valid_i) begin
            laneGrant[BRU] = 1'b1;
            lane1Ptr_d     = 1'b0;
         end
         // First requester found walking forward from the pointer wins lane 2.
         for (int k = 0; k < 3; k++) begin
            if (!found && lane2Req[cand]) begin
               found      = 1'b1;
               lane2Ptr_d = wrapInc(cand);
               unique case (cand)
                  2'd0:    laneGrant[AGU]  = 1'b1;
                  2'd1:    laneGrant[ALU2] = 1'b1;
                  default: laneGrant[SP]   = 1'b1;
               endcase
            end
            cand = wrapInc(cand);
         end
      end
   end

   always_comb begin
      bus1_d = '0;
      bus2_d = '0;
      if (mdGrant) begin
         bus1_d = mul_div_bus1_i;
         bus2_d = mul_div_bus2_i;
      end else begin
         if (laneGrant[ALU1])      bus1_d = alu1_bus_i;
         else if (laneGrant[BRU])  bus1_d = bru_bus_i;
         if (laneGrant[AGU])       bus2_d = agu_bus_i;
         else if (laneGrant[ALU2]) bus2_d = alu2_bus_i;
         else if (laneGrant[SP])   bus2_d = sp_bus_i;
      end
   end

`ifdef COMMIT_ARB_STARVE_GUARD_EN
   logic [3:0]      waitCnt_q [NREQ];
   logic [NREQ-1:0] starving;

   always_comb begin
      starving = '0;
      for (int i = 0; i < NREQ; i++) begin
         starving[i] = reqValid[i] && (waitCnt_q[i] >= 4'(STARVE_LIMIT));
      end
   end
   assign starveHit = |starving;

   // Counts consecutive cycles a requester has waited; saturates rather than wrapping.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NREQ; i++) begin
         if (reset || flush_i || !reqValid[i] || laneGrant[i]) begin
            waitCnt_q[i] <= 4'd0;
         end else if (waitCnt_q[i] != 4'd15) begin
            waitCnt_q[i] <= waitCnt_q[i] + 4'd1;
         end
      end
   end
`else
   assign starveHit = 1'b0;
`endif

   // Output stage reloads only when commit can take it; pointers follow lane grants only.
   always_ff @(posedge clk) begin
      if (reset || flush_i) begin
         valid1_q   <= 1'b0;
         valid2_q   <= 1'b0;
         bus1_q     <= '0;
         bus2_q     <= '0;
         lane1Ptr_q <= 1'b0;
         lane2Ptr_q <= 2'd0;
      end else begin
         lane1Ptr_q <= lane1Ptr_d;
         lane2Ptr_q <= lane2Ptr_d;
         if (take) begin
            valid1_q <= mdGrant || laneGrant[ALU1] || laneGrant[BRU];
            valid2_q <= mdGrant || laneGrant[AGU] || laneGrant[ALU2] || laneGrant[SP];
            bus1_q   <= bus1_d;
            bus2_q   <= bus2_d;
         end
      end
   end

   assign alu1_ready_o    = laneGrant[ALU1];
   assign bru_ready_o     = laneGrant[BRU];
   assign agu_ready_o     = laneGrant[AGU];
   assign alu2_ready_o    = laneGrant[ALU2];
   assign sp_ready_o      = laneGrant[SP];
   assign mul_div_ready_o = mdGrant;
   assign commit_valid1_o = valid1_q;
   assign commit_valid2_o = valid2_q;
   assign commit_bus1_o   = bus1_q;
   assign commit_bus2_o   = bus2_q;

endmodule

// File: tb/tb_commit_port_arbiter.sv
// Randomized and directed bench for commit_port_arbiter against a queue-free behavioural model.
// Follows COMMIT_ARB_STARVE_GUARD_EN so the model matches whichever build is compiled.
module tb_commit_port_arbiter;

   localparam int PW    = 32;
   localparam int LIMIT = 3;
`ifdef COMMIT_ARB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   // Requester index: 0 alu1, 1 bru, 2 agu, 3 alu2, 4 sp, 5 mul_div (pay[5]/pay[6] are its two lanes).
   logic          clk = 1'b0;
   logic          rst, flush, cr;
   logic          vld [6];
   logic [PW-1:0] pay [7];
   logic [5:0]    rdy;
   logic          cv1, cv2;
   logic [PW-1:0] cb1, cb2;

   always #5 clk = ~clk;

   commit_port_arbiter #(.PAYLOAD_W(PW), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .reset(rst), .flush_i(flush),
      .alu1_valid_i(vld[0]), .alu1_ready_o(rdy[0]), .alu1_bus_i(pay[0]),
      .bru_valid_i(vld[1]),  .bru_ready_o(rdy[1]),  .bru_bus_i(pay[1]),
      .agu_valid_i(vld[2]),  .agu_ready_o(rdy[2]),  .agu_bus_i(pay[2]),
      .alu2_valid_i(vld[3]), .alu2_ready_o(rdy[3]), .alu2_bus_i(pay[3]),
      .sp_valid_i(vld[4]),   .sp_ready_o(rdy[4]),   .sp_bus_i(pay[4]),
      .mul_div_valid_i(vld[5]), .mul_div_ready_o(rdy[5]),
      .mul_div_bus1_i(pay[5]), .mul_div_bus2_i(pay[6]),
      .commit_ready_i(cr),
      .commit_bus1_o(cb1), .commit_bus2_o(cb2),
      .commit_valid1_o(cv1), .commit_valid2_o(cv2)
   );

   int            tests = 0;
   int            fails = 0;
   bit            mV1, mV2;
   logic [PW-1:0] mB1, mB2;
   int            pref1, pref2;
   int            waitc [5];
   bit            pending [6];
   logic [5:0]    obsRdy;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One cycle: inputs already driven at the falling edge; check grants, clock, check outputs.
   task automatic step();
      bit         take, en, starve;
      int         g1, g2;
      logic [5:0] expRdy;
      #1;
      take   = !(mV1 || mV2) || cr;
      en     = take && !flush && !rst;
      starve = 1'b0;
      if (GUARD)
         for (int f = 0; f < 5; f++)
            if (vld[f] && waitc[f] >= LIMIT) starve = 1'b1;
      expRdy = '0;
      g1 = -1;
      g2 = -1;
      if (en && vld[5] && !starve) begin
         expRdy[5] = 1'b1;
      end else if (en) begin
         if (vld[pref1])          g1 = pref1;
         else if (vld[1 - pref1]) g1 = 1 - pref1;
         for (int k = 0; k < 3; k++)
            if (g2 < 0 && vld[2 + (pref2 + k) % 3]) g2 = (pref2 + k) % 3;
         if (g1 >= 0) expRdy[g1] = 1'b1;
         if (g2 >= 0) expRdy[2 + g2] = 1'b1;
      end
      obsRdy = rdy;
      checkOutput("ready", rdy, expRdy);

      if (rst || flush) begin
         mV1 = 0; mV2 = 0; mB1 = '0; mB2 = '0; pref1 = 0; pref2 = 0;
         for (int f = 0; f < 5; f++) waitc[f] = 0;
      end else begin
         if (take) begin
            if (expRdy[5]) begin
               mV1 = 1; mB1 = pay[5]; mV2 = 1; mB2 = pay[6];
            end else begin
               mV1 = (g1 >= 0);
               mV2 = (g2 >= 0);
               if (g1 >= 0) mB1 = pay[g1];
               if (g2 >= 0) mB2 = pay[2 + g2];
            end
         end
         if (g1 >= 0) pref1 = 1 - g1;
         if (g2 >= 0) pref2 = (g2 + 1) % 3;
         for (int f = 0; f < 5; f++)
            waitc[f] = (!vld[f] || expRdy[f]) ? 0 : ((waitc[f] < 15) ? waitc[f] + 1 : 15);
      end
      for (int f = 0; f < 6; f++) pending[f] = vld[f] && !expRdy[f] && !(rst || flush);

      @(posedge clk);
      @(negedge clk);
      checkOutput("valid1", cv1, mV1);
      checkOutput("valid2", cv2, mV2);
      if (mV1) checkOutput("bus1", cb1, mB1);
      if (mV2) checkOutput("bus2", cb2, mB2);
   endtask

   task automatic clearIn();
      flush = 0;
      cr    = 1;
      for (int f = 0; f < 6; f++) begin
         vld[f]     = 0;
         pending[f] = 0;
      end
   endtask

   task automatic doReset();
      clearIn();
      rst = 1;
      step();
      rst = 0;
   endtask

   // Random inputs honouring the hold-until-ready protocol.
   task automatic applyStimulus();
      rst   = ($urandom % 300 == 0);
      flush = ($urandom % 40 == 0);
      cr    = ($urandom % 4 != 0);
      for (int f = 0; f < 6; f++) begin
         if (!pending[f]) begin
            vld[f] = (f == 5) ? ($urandom % 4 == 0) : ($urandom % 3 != 0);
            pay[f] = $urandom;
            if (f == 5) pay[6] = $urandom;
         end
      end
   endtask

   initial begin
      mV1 = 0; mV2 = 0; mB1 = '0; mB2 = '0; pref1 = 0; pref2 = 0;
      for (int f = 0; f < 5; f++) waitc[f] = 0;
      for (int p = 0; p < 7; p++) pay[p] = '0;
      @(negedge clk);
      doReset();
      checkOutput("rst_bus", {cb1, cb2}, 64'h0);
      checkOutput("rst_rdy", obsRdy, 6'h0);

      // Both lanes granted in the request cycle, payloads one cycle later.
      vld[0] = 1; vld[3] = 1; pay[0] = 32'hA1A1_0001; pay[3] = 32'hA2A2_0002;
      step();
      checkOutput("tp1_rdy", {obsRdy[0], obsRdy[3]}, 2'b11);
      checkOutput("tp1_bus", {cb1, cb2}, {32'hA1A1_0001, 32'hA2A2_0002});

      // Lane-1 round robin starts at alu1 and alternates.
      doReset();
      vld[0] = 1; vld[1] = 1;
      for (int i = 0; i < 6; i++) begin
         pay[0] = $urandom; pay[1] = $urandom;
         step();
         checkOutput("tp2_alt", {obsRdy[1], obsRdy[0]}, (i % 2 == 0) ? 2'b01 : 2'b10);
      end

      // mul_div beats agu and fills both lanes.
      doReset();
      vld[5] = 1; vld[2] = 1; pay[5] = 32'hD00D_0001; pay[6] = 32'hD00D_0002; pay[2] = 32'h0A60_0003;
      step();
      checkOutput("tp3_rdy", {obsRdy[5], obsRdy[2]}, 2'b10);
      checkOutput("tp3_bus", {cb1, cb2}, {32'hD00D_0001, 32'hD00D_0002});

      // Continuous mul_div vs sp: sp wins every 4th cycle only with the guard.
      doReset();
      vld[5] = 1; vld[4] = 1;
      for (int i = 0; i < 8; i++) begin
         step();
         checkOutput("tp4_sp", obsRdy[4], GUARD && (i % 4 == 3));
      end

      // Stall with full output stage, then release.
      doReset();
      vld[0] = 1; pay[0] = 32'h0000_1111;
      step();
      pay[0] = 32'h0000_2222; vld[3] = 1; pay[3] = 32'h0000_3333; cr = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         checkOutput("tp5_stall", obsRdy, 6'h0);
      end
      cr = 1;
      step();
      checkOutput("tp5_go", {obsRdy[0], obsRdy[3]}, 2'b11);

      // Flush with full output and alu1 pending resets state and pointers.
      doReset();
      vld[0] = 1; cr = 0; pay[0] = 32'h0000_4444;
      step();
      step();
      flush = 1;
      step();
      checkOutput("tp6_flush_rdy", obsRdy[0], 1'b0);
      checkOutput("tp6_flush_v", {cv1, cv2}, 2'b00);
      flush = 0; vld[1] = 1; pay[1] = 32'h0000_5555;
      step();
      checkOutput("tp6_ptr", {obsRdy[1], obsRdy[0]}, 2'b01);

      doReset();
      for (int n = 0; n < 3000; n++) begin
         applyStimulus();
         step();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
